mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 14 +
 rtl/mem_resp_lfsr.sv | 12 +
 rtl/mem_responder.sv | 80 ++++++++
 tb/tb_mem_responder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for mem_responder
package mem_resp_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0] strb_t;
  localparam data_t ErrData = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  typedef enum logic [1:0] {IDLE, STALL, GRANT} gnt_state_e;
  typedef struct packed {
    logic  valid;
    logic  err;
    data_t data;
  } resp_t;
endpackage

// File: rtl/mem_resp_lfsr.sv
// mem_resp_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) stepping every cycle
module mem_resp_lfsr
  import mem_resp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [15:0] lfsr_o
);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) lfsr_o <= LfsrSeed;
    else lfsr_o <= {lfsr_o[14:0], lfsr_o[15] ^ lfsr_o[13] ^ lfsr_o[12] ^ lfsr_o[10]};
endmodule

// File: rtl/mem_responder.sv
// mem_responder: pipelined 64-bit memory responder; MEM_RESP_RANDOM_STALL_EN enables random grant stalls
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int    Depth       = 1024,
  parameter addr_t BaseAddr    = 32'h8000_0000,
  parameter int    RespLatency = 1,
  parameter int    MaxStall    = 3
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  req_i,
  input  logic  we_i,
  input  addr_t addr_i,
  input  data_t wdata_i,
  input  strb_t strb_i,
  output logic  gnt_o,
  output logic  rvalid_o,
  output data_t rdata_o,
  output logic  err_o
);
  localparam int Aw = Depth > 1 ? $clog2(Depth) : 1;
  data_t mem [Depth];
  addr_t idx;
  data_t rd;
  logic in_range, acc;
  resp_t ent;
  resp_t pipe [RespLatency];
  assign idx = (addr_i - BaseAddr) >> 3;
  assign in_range = addr_i >= BaseAddr && idx < addr_t'(Depth);
  assign acc = req_i && gnt_o;
  assign rd = we_i ? '0 : in_range ? mem[idx[Aw-1:0]] : ErrData;
  assign ent = acc ? {1'b1, !in_range, rd} : '0;
  assign {rvalid_o, err_o, rdata_o} = pipe[RespLatency-1];
  always_ff @(posedge clk_i)
    if (acc && we_i && in_range)
      for (int b = 0; b < 8; b++)
        if (strb_i[b]) mem[idx[Aw-1:0]][8*b +: 8] <= wdata_i[8*b +: 8];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < RespLatency; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= ent;
      for (int i = 1; i < RespLatency; i++) pipe[i] <= pipe[i-1];
    end
`ifdef MEM_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr;
  logic [2:0] cnt, stall;
  logic lfsr_unused;
  gnt_state_e state;
  mem_resp_lfsr u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .lfsr_o (lfsr)
  );
  assign lfsr_unused = ^lfsr[15:3];
  assign stall = 3'(32'(lfsr[2:0]) % (MaxStall + 1));
  assign gnt_o = state == GRANT && req_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (req_i) begin
          cnt <= stall;
          state <= stall == 3'd0 ? GRANT : STALL;
        end
        STALL: if (!req_i) state <= IDLE;
          else begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) state <= GRANT;
          end
        default: state <= IDLE;
      endcase
    end
`else
  assign gnt_o = req_i && rst_ni;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench driving latency-1 and latency-3 mem_responder instances
module tb_mem_responder;
  localparam int Depth = 1024;
  localparam logic [31:0] Base = 32'h8000_0000;
  localparam int MaxStall = 3;
  localparam logic [63:0] Dead = 64'hDEAD_BEEF_DEAD_BEEF;
  typedef struct {
    int          cyc;
    logic        err;
    logic [63:0] data;
  } exp_t;
  logic clk = 0, rst_n = 0, req = 0, we = 0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [7:0] strb = '0;
  logic gnt1, gnt3, rv1, rv3, err1, err3;
  logic [63:0] rd1, rd3;
  int cyc = 0, checks = 0, fails = 0;
  exp_t q1[$], q3[$];
  exp_t e1, e3;
  logic [63:0] mem_m [int];
  int widx [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.Depth(Depth), .BaseAddr(Base), .RespLatency(1), .MaxStall(MaxStall)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .strb_i(strb), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1), .err_o(err1));
  mem_responder #(.Depth(Depth), .BaseAddr(Base), .RespLatency(3), .MaxStall(MaxStall)) dut_l3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .strb_i(strb), .gnt_o(gnt3), .rvalid_o(rv3), .rdata_o(rd3), .err_o(err3));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    check("lat1 gnt without req", gnt1 & ~req, 0);
    check("lat3 gnt without req", gnt3 & ~req, 0);
    if (rv1) begin
      check("lat1 rvalid has pending entry", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("lat1 rdata", rd1, e1.data);
        check("lat1 err", err1, e1.err);
        check("lat1 timing", cyc, e1.cyc);
      end
    end else check("lat1 idle rdata", rd1, 0);
    if (rv3) begin
      check("lat3 rvalid has pending entry", q3.size() != 0, 1);
      if (q3.size() != 0) begin
        e3 = q3.pop_front();
        check("lat3 rdata", rd3, e3.data);
        check("lat3 err", err3, e3.err);
        check("lat3 timing", cyc, e3.cyc);
      end
    end else check("lat3 idle rdata", rd3, 0);
  end

  // Called at negedge+1; returns at negedge+1 after acceptance, leaving req high for back-to-back use.
  task automatic issue(input logic w, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    int waits = 0;
    int idx;
    logic in;
    exp_t e;
    req = 1; we = w; addr = a; wdata = d; strb = s;
    #1;
    while (!gnt1 && waits < 20) begin
      @(negedge clk); #2;
      waits++;
    end
    check("grant within bound", waits < 20, 1);
    if (waits >= 20) begin
      req = 0;
      @(negedge clk); #1;
      return;
    end
`ifdef MEM_RESP_RANDOM_STALL_EN
    check("grant stall range", waits >= 1 && waits <= MaxStall + 1, 1);
`else
    check("zero-wait grant", waits, 0);
`endif
    in = a >= Base && ((a - Base) >> 3) < Depth;
    idx = int'((a - Base) >> 3);
    e.err = !in;
    e.data = w ? 64'd0 : in ? mem_m[idx] : Dead;
    if (in && w)
      for (int b = 0; b < 8; b++)
        if (s[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
    e.cyc = cyc + 1; q1.push_back(e);
    e.cyc = cyc + 3; q3.push_back(e);
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    req = 0;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  function automatic logic [31:0] waddr(input int k, input logic [2:0] lo);
    return Base + 32'(widx[k]) * 8 + 32'(lo);
  endfunction

  initial begin
    for (int k = 0; k < 16; k++) widx[k] = k < 14 ? k : Depth - 16 + k;
    @(negedge clk); #1;
    req = 1;
    #1;
    check("reset gnt1", gnt1, 0);
    check("reset gnt3", gnt3, 0);
    check("reset rvalid", {rv1, rv3}, 0);
    check("reset err", {err1, err3}, 0);
    check("reset rdata1", rd1, 0);
    check("reset rdata3", rd3, 0);
    req = 0;
    @(negedge clk); #1;
    rst_n = 1;
    idle(2);
    for (int k = 0; k < 16; k++) issue(1, waddr(k, 0), {$urandom, $urandom}, 8'hFF);
    issue(1, 32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF);
    issue(0, 32'h8000_0008, '0, '0);
    issue(1, 32'h8000_0028, 64'd0, 8'hFF);
    issue(1, 32'h8000_0028, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    issue(0, 32'h8000_0028, '0, '0);
    issue(0, 32'h7FFF_FFF8, '0, '0);
    issue(0, Base + 32'(8 * Depth), '0, '0);
    issue(1, Base + 32'(8 * Depth), 64'h0123_4567_89AB_CDEF, 8'hFF);
    issue(0, Base + 32'(8 * (Depth - 1)), '0, '0);
    idle(4);
    for (int k = 0; k < 10; k++) issue(0, waddr(int'($urandom_range(15)), 3'($urandom)), '0, '0);
    idle(4);
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = $urandom_range(7) == 0 ? ($urandom_range(1) ? 32'h7FFF_FFF8 - 32'($urandom_range(64))
                                                       : Base + 32'(8 * Depth) + 32'($urandom_range(64)))
                                 : waddr(int'($urandom_range(15)), 3'($urandom));
      issue(1'($urandom), a, {$urandom, $urandom}, 8'($urandom));
      if ($urandom_range(3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(6);
    issue(0, waddr(1, 0), '0, '0);
    issue(0, waddr(2, 0), '0, '0);
    rst_n = 0;
    req = 0;
    #1;
    check("mid reset rvalid", {rv1, rv3}, 0);
    check("mid reset err", {err1, err3}, 0);
    check("mid reset rdata1", rd1, 0);
    check("mid reset rdata3", rd3, 0);
    check("in-flight at reset", q3.size(), 2);
    q1.delete();
    q3.delete();
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1;
    idle(8);
    for (int k = 0; k < 6; k++) issue(0, waddr(k, 0), '0, '0);
    for (int t = 0; t < 20 && (q1.size() != 0 || q3.size() != 0); t++) idle(1);
    check("lat1 queue drained", q1.size(), 0);
    check("lat3 queue drained", q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
